// File: rtl/strand_deserializer.sv
// ---------------------------------------------------------------------------
// strand_deserializer
//
// Front end of the BCH decode path for DNA reads. Nucleotides arrive one per
// valid/ready handshake; 32 of them are packed MSB-first into a 64-bit
// codeword, which is handed to the decoder with a one-cycle start pulse. Once
// the decoder reports completion, its 39-bit payload is offered downstream on
// a valid/ready port. Strands of the wrong length never reach the decoder:
// they are discarded and reported with a one-cycle frame_err pulse.
//
// Ports
//   clk              system clock (single domain)
//   resetN           asynchronous active-low reset
//   nuc_valid        nucleotide present on nuc
//   nuc[1:0]         nucleotide code A=00 C=01 G=10 T=11
//   nuc_last         final nucleotide of a strand (qualified by nuc_valid)
//   nuc_ready        block accepts a nucleotide this cycle
//   dec_start        one-cycle start pulse to the decoder
//   dec_message[63:0]  codeword for the decoder, held until the next load
//   dec_finish_flag  decoder finish flag (level)
//   dec_decoded_msg[38:0]  decoder payload
//   data_out[38:0]   decoded payload toward downstream
//   data_valid       data_out is valid
//   data_ready       downstream accepts data_out
//   frame_err        one-cycle pulse when a strand is dropped for length
//   strand_count     payloads delivered, wraps modulo 2^COUNT_W
// ---------------------------------------------------------------------------
module strand_deserializer #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               nuc_valid,
  input  logic [1:0]         nuc,
  input  logic               nuc_last,
  output logic               nuc_ready,
  output logic               dec_start,
  output logic [63:0]        dec_message,
  input  logic               dec_finish_flag,
  input  logic [38:0]        dec_decoded_msg,
  output logic [38:0]        data_out,
  output logic               data_valid,
  input  logic               data_ready,
  output logic               frame_err,
  output logic [COUNT_W-1:0] strand_count
);

  typedef enum logic [2:0] {
    COLLECT   = 3'd0,
    DROP      = 3'd1,
    LAUNCH    = 3'd2,
    WAIT_DONE = 3'd3,
    OUTPUT    = 3'd4
  } state_t;

  localparam logic [4:0] LAST_INDEX = 5'd31;

  state_t              state_reg, state_next;
  logic [63:0]         shreg_reg, shreg_next;
  logic [4:0]          index_reg, index_next;
  logic [63:0]         msg_reg, msg_next;
  logic                seen_low_reg, seen_low_next;
  logic [38:0]         data_reg, data_next;
  logic [COUNT_W-1:0]  count_reg, count_next;

  // Handshake-facing outputs are registered so that every one of them sits
  // at zero while reset is asserted; their next values are decoded from the
  // next state, which keeps them aligned with the state register.
  logic                ready_reg, ready_next;
  logic                start_reg, start_next;
  logic                valid_reg, valid_next;
  logic                ferr_reg, ferr_next;

  logic                accept;
  logic [63:0]         shifted;

  assign accept = nuc_valid & ready_reg;

  // Shift-by-one-nucleotide view of the packing register. The newest code
  // enters at the bottom, so after 32 shifts the first nucleotide of the
  // strand sits in bits [63:62].
  assign shifted[1:0] = nuc;
  for (genvar gi = 1; gi < 32; gi++) begin : g_shift
    assign shifted[2*gi+1 -: 2] = shreg_reg[2*gi-1 -: 2];
  end

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_reg    <= COLLECT;
      shreg_reg    <= '0;
      index_reg    <= '0;
      msg_reg      <= '0;
      seen_low_reg <= 1'b0;
      data_reg     <= '0;
      count_reg    <= '0;
      ready_reg    <= 1'b0;
      start_reg    <= 1'b0;
      valid_reg    <= 1'b0;
      ferr_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shreg_reg    <= shreg_next;
      index_reg    <= index_next;
      msg_reg      <= msg_next;
      seen_low_reg <= seen_low_next;
      data_reg     <= data_next;
      count_reg    <= count_next;
      ready_reg    <= ready_next;
      start_reg    <= start_next;
      valid_reg    <= valid_next;
      ferr_reg     <= ferr_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and datapath logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    shreg_next    = shreg_reg;
    index_next    = index_reg;
    msg_next      = msg_reg;
    seen_low_next = seen_low_reg;
    data_next     = data_reg;
    count_next    = count_reg;
    ferr_next     = 1'b0;

    unique case (state_reg)
      COLLECT: begin
        if (accept) begin
          shreg_next = shifted;
          index_next = index_reg + 5'd1;
          if (nuc_last) begin
            index_next = '0;
            if (index_reg == LAST_INDEX) begin
              // Exactly 32 nucleotides: freeze the codeword for the decoder.
              msg_next   = shifted;
              state_next = LAUNCH;
            end else begin
              ferr_next = 1'b1;
            end
          end else if (index_reg == LAST_INDEX) begin
            // Too long: the index wraps to zero here, and the remainder of
            // the strand is swallowed in DROP.
            state_next = DROP;
          end
        end
      end

      DROP: begin
        if (accept && nuc_last) begin
          ferr_next  = 1'b1;
          index_next = '0;
          state_next = COLLECT;
        end
      end

      LAUNCH: begin
        // The decoder's flag may still be high from the previous strand; a
        // completion only counts once the flag has been seen low.
        seen_low_next = 1'b0;
        state_next    = WAIT_DONE;
      end

      WAIT_DONE: begin
        if (!dec_finish_flag) begin
          seen_low_next = 1'b1;
        end else if (seen_low_reg) begin
          data_next  = dec_decoded_msg;
          state_next = OUTPUT;
        end
      end

      OUTPUT: begin
        if (valid_reg && data_ready) begin
          count_next = count_reg + {{(COUNT_W-1){1'b0}}, 1'b1};
          state_next = COLLECT;
        end
      end

      default: begin
        state_next = COLLECT;
      end
    endcase

    ready_next = (state_next == COLLECT) || (state_next == DROP);
    start_next = (state_next == LAUNCH);
    valid_next = (state_next == OUTPUT);
  end

  assign nuc_ready    = ready_reg;
  assign dec_start    = start_reg;
  assign dec_message  = msg_reg;
  assign data_out     = data_reg;
  assign data_valid   = valid_reg;
  assign frame_err    = ferr_reg;
  assign strand_count = count_reg;

endmodule

// File: tb/tb_strand_deserializer.sv
// ---------------------------------------------------------------------------
// tb_strand_deserializer
//
// Random and directed strands are driven into strand_deserializer. A small
// behavioural decoder answers dec_start with a delayed finish flag. Expected
// codewords and payloads are queued when a strand is sent; monitors pop and
// compare them when dec_start or the output handshake appears.
// ---------------------------------------------------------------------------
module tb_strand_deserializer;

  localparam int COUNT_W = 16;

  logic               clk = 1'b0;
  logic               resetN = 1'b0;
  logic               nuc_valid = 1'b0;
  logic [1:0]         nuc = 2'b00;
  logic               nuc_last = 1'b0;
  logic               nuc_ready;
  logic               dec_start;
  logic [63:0]        dec_message;
  logic               dec_finish_flag = 1'b0;
  logic [38:0]        dec_decoded_msg = '0;
  logic [38:0]        data_out;
  logic               data_valid;
  logic               data_ready = 1'b0;
  logic               frame_err;
  logic [COUNT_W-1:0] strand_count;

  int checks = 0;
  int errors = 0;

  logic [63:0] cw_q[$];
  logic [38:0] pay_q[$];
  int          exp_err   = 0;
  int          seen_err  = 0;
  int          exp_deliv = 0;
  int          hs_count  = 0;
  logic        hold_low  = 1'b0;

  strand_deserializer #(.COUNT_W(COUNT_W)) dut (
    .clk             (clk),
    .resetN          (resetN),
    .nuc_valid       (nuc_valid),
    .nuc             (nuc),
    .nuc_last        (nuc_last),
    .nuc_ready       (nuc_ready),
    .dec_start       (dec_start),
    .dec_message     (dec_message),
    .dec_finish_flag (dec_finish_flag),
    .dec_decoded_msg (dec_decoded_msg),
    .data_out        (data_out),
    .data_valid      (data_valid),
    .data_ready      (data_ready),
    .frame_err       (frame_err),
    .strand_count    (strand_count)
  );

  always #5 clk = ~clk;

  // Stand-in for the BCH decoder's transfer function.
  function automatic logic [38:0] dec_model(input logic [63:0] m);
    return m[63:25] ^ m[38:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_nuc_ready"},    64'(nuc_ready),    64'd0);
    chk({tag, "_dec_start"},    64'(dec_start),    64'd0);
    chk({tag, "_dec_message"},  dec_message,       64'd0);
    chk({tag, "_data_out"},     64'(data_out),     64'd0);
    chk({tag, "_data_valid"},   64'(data_valid),   64'd0);
    chk({tag, "_frame_err"},    64'(frame_err),    64'd0);
    chk({tag, "_strand_count"}, 64'(strand_count), 64'd0);
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  // Entered and left at posedge+1. Holds the nucleotide until accepted.
  task automatic send_nuc(input logic [1:0] n, input logic last);
    int wait_cyc;
    if ($urandom_range(0, 3) == 0) begin
      nuc_valid = 1'b0;
      repeat ($urandom_range(1, 2)) align();
    end
    nuc_valid = 1'b1;
    nuc       = n;
    nuc_last  = last;
    wait_cyc  = 0;
    forever begin
      @(negedge clk);
      if (nuc_ready) break;
      wait_cyc++;
      if (wait_cyc > 400) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout nuc_ready actual=0 required=1");
        break;
      end
    end
    align();
    nuc_valid = 1'b0;
    nuc_last  = 1'b0;
  endtask

  // mode 0: random nucleotides, 1: all A, 2: repeating A C G T
  task automatic send_strand(input int len, input int mode);
    logic [63:0] cw;
    logic [1:0]  n;
    cw = '0;
    align();
    for (int i = 0; i < len; i++) begin
      if (mode == 1)      n = 2'b00;
      else if (mode == 2) n = 2'(i % 4);
      else                n = 2'($urandom_range(0, 3));
      if (i < 32) cw = (cw << 2) | 64'(n);
      send_nuc(n, i == len - 1);
    end
    if (len == 32) begin
      cw_q.push_back(cw);
      pay_q.push_back(dec_model(cw));
      exp_deliv++;
    end else begin
      exp_err++;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((cw_q.size() != 0 || pay_q.size() != 0 || data_valid) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout pending_payloads actual=%0d required=0", pay_q.size());
    end
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!data_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(data_valid), 64'd1);
  endtask

  // Downstream ready: random unless held low.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (hold_low) data_ready = 1'b0;
      else          data_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Decoder model: flag drops two cycles after start, rises after a random
  // latency with the payload, and then stays high until the next start.
  initial begin
    logic [63:0] m_cap;
    int          lat;
    forever begin
      @(negedge clk);
      if (resetN && dec_start) begin
        m_cap = dec_message;
        align();
        align();
        dec_finish_flag = 1'b0;
        lat = $urandom_range(1, 8);
        repeat (lat) @(posedge clk);
        #1;
        chk("dec_message_stable", dec_message, m_cap);
        dec_decoded_msg = dec_model(m_cap);
        dec_finish_flag = 1'b1;
      end
    end
  end

  // Output monitor.
  initial begin
    logic        prev_start;
    logic [63:0] exp_cw;
    logic [38:0] exp_pay;
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (resetN) begin
        if (dec_start) begin
          chk("dec_start_width", 64'(prev_start), 64'd0);
          checks++;
          if (cw_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_dec_start actual=1 required=0");
          end else begin
            exp_cw = cw_q.pop_front();
            chk("dec_message", dec_message, exp_cw);
          end
        end
        prev_start = dec_start;
        if (frame_err) seen_err++;
        if (data_valid) chk("nuc_ready_while_valid", 64'(nuc_ready), 64'd0);
        if (data_valid && data_ready) begin
          checks++;
          if (pay_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_payload actual=%h required=none", data_out);
          end else begin
            exp_pay = pay_q.pop_front();
            chk("data_out", 64'(data_out), 64'(exp_pay));
          end
          chk("strand_count_before_hs", 64'(strand_count), 64'(hs_count % (1 << COUNT_W)));
          hs_count++;
        end
      end else begin
        prev_start = 1'b0;
      end
    end
  end

  initial begin
    int len;
    int r;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    align();
    resetN = 1'b1;
    @(negedge clk);
    chk("nuc_ready_first_cycle", 64'(nuc_ready), 64'd0);
    @(negedge clk);
    chk("nuc_ready_after_release", 64'(nuc_ready), 64'd1);

    // All-A strand, then the ACGT strand
    send_strand(32, 1);
    wait_idle();
    chk("count_after_first", 64'(strand_count), 64'd1);
    send_strand(32, 2);
    wait_idle();

    // Short strand followed by a good one
    send_strand(10, 0);
    send_strand(32, 0);
    wait_idle();
    chk("short_frame_err_count", 64'(seen_err), 64'(exp_err));

    // Long strand: no launch, count unchanged
    send_strand(40, 0);
    wait_idle();
    @(negedge clk);
    chk("long_frame_err_count", 64'(seen_err), 64'(exp_err));
    chk("long_count_unchanged", 64'(strand_count), 64'(exp_deliv));

    // Downstream stalled for 20 cycles with a second strand waiting
    hold_low = 1'b1;
    send_strand(32, 0);
    wait_valid("stall_valid");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("stall_nuc_ready", 64'(nuc_ready), 64'd0);
    end
    fork
      send_strand(32, 0);
      begin
        repeat (3) @(posedge clk);
        #1;
        hold_low = 1'b0;
      end
    join
    wait_idle();

    // Reset with 15 nucleotides buffered
    align();
    for (int i = 0; i < 15; i++) send_nuc(2'($urandom_range(0, 3)), 1'b0);
    resetN = 1'b0;
    exp_deliv = 0;
    hs_count  = 0;
    @(negedge clk);
    check_reset_outputs("midstrand_reset");
    align();
    resetN = 1'b1;
    send_strand(32, 0);
    wait_idle();

    // Reset with a payload pending downstream
    hold_low = 1'b1;
    send_strand(32, 0);
    wait_valid("pending_valid");
    align();
    resetN = 1'b0;
    pay_q.delete();
    exp_deliv = 0;
    hs_count  = 0;
    @(negedge clk);
    check_reset_outputs("pending_reset");
    align();
    resetN   = 1'b1;
    hold_low = 1'b0;

    // Random strands
    for (int s = 0; s < 30; s++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       len = 32;
      else if (r == 7) len = $urandom_range(2, 31);
      else if (r == 8) len = $urandom_range(33, 45);
      else             len = 40;
      send_strand(len, 0);
    end
    wait_idle();
    repeat (3) @(negedge clk);

    chk("final_strand_count", 64'(strand_count), 64'(exp_deliv % (1 << COUNT_W)));
    chk("final_frame_err_count", 64'(seen_err), 64'(exp_err));
    chk("final_codewords_left", 64'(cw_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/strand_deserializer.md
# strand_deserializer

Upstream feeder for the BCH `decoder` block in the DNA read path. It accepts nucleotides one per handshake from the sequencer interface and packs 32 of them into a 64-bit received codeword. It launches the decoder with a single-cycle start pulse, waits for the decoder's finish flag, and presents the 39-bit decoded payload on a valid/ready output. Malformed strands (wrong length) are dropped and flagged; the decoder never sees them.

## Interface
Parameters:
- COUNT_W, 16, width of the delivered-strand counter.

Ports:
- clk  in  1  system clock, single domain.
- resetN  in  1  asynchronous, active-low reset.
- nuc_valid  in  1  nucleotide present on nuc.
- nuc  in  2  nucleotide code: A=00, C=01, G=10, T=11.
- nuc_last  in  1  marks the final nucleotide of a strand; qualified by nuc_valid.
- nuc_ready  out  1  block accepts a nucleotide this cycle.
- dec_start  out  1  start pulse to the decoder.
- dec_message  out  64  codeword to the decoder.
- dec_finish_flag  in  1  decoder finish flag (level).
- dec_decoded_msg  in  39  decoder payload.
- data_out  out  39  decoded payload.
- data_valid  out  1  data_out is valid.
- data_ready  in  1  downstream accepts data_out.
- frame_err  out  1  one-cycle pulse when a strand is dropped for length.
- strand_count  out  COUNT_W  number of payloads delivered; wraps modulo 2^COUNT_W.

## Operation
- States: COLLECT, DROP, LAUNCH, WAIT_DONE, OUTPUT.
- Accept = nuc_valid & nuc_ready. nuc_ready = 1 in COLLECT and DROP only.
- COLLECT: on each accept, shift {shreg[61:0], nuc} into a 64-bit register. The first nucleotide ends in bits [63:62]. Increment the 5-bit index.
  - Accept with nuc_last and index==31: load dec_message from the completed shift value, clear the index, go to LAUNCH.
  - Accept with nuc_last and index<31: pulse frame_err, clear the index, stay in COLLECT.
  - Accept with index==31 and no nuc_last: go to DROP.
- DROP: discard nucleotides until an accept with nuc_last. On that accept, pulse frame_err, clear the index, go to COLLECT.
- LAUNCH: dec_start=1 for exactly this one cycle. Clear seen_low. Go to WAIT_DONE.
- WAIT_DONE: set seen_low when dec_finish_flag==0. When seen_low & dec_finish_flag: capture dec_decoded_msg into data_out and go to OUTPUT. A finish flag still high from the previous strand is ignored until it has dropped.
- OUTPUT: data_valid=1. On data_valid & data_ready: increment strand_count, drop data_valid, go to COLLECT.
- dec_message holds its value from load until the next load. It is stable for the entire decode.
- A new strand is never launched before the previous payload is consumed, so the decoder is always idle when dec_start pulses.

## Timing
- Reset values: nuc_ready=0, dec_start=0, dec_message=0, data_out=0, data_valid=0, frame_err=0, strand_count=0. The state is COLLECT, and nuc_ready rises 1 cycle after reset release.
- Edge E accepts the 32nd nucleotide with nuc_last:
  - dec_message is valid and the state is LAUNCH from E.
  - dec_start is high during the cycle after E.
  - nuc_ready is low from E onward.
- Finish detection:
  - The decoder clears its flag 2 cycles after dec_start rises; seen_low covers that gap.
  - data_valid rises the cycle after dec_finish_flag is sampled high with seen_low set.
- frame_err is high for the one cycle following the offending accept.
- resetN asserted mid-operation returns to the reset state immediately: the partial strand is lost and any pending payload is discarded.
- nuc_valid while nuc_ready=0 is ignored; the upstream source must hold its data.
- Minimum spacing between strands: 32 accept cycles, plus decode latency, plus 1 output cycle.

## Test plan
- Strand of 32 A's (all 00) with nuc_last on the 32nd:
  - dec_message=64'h0 and dec_start pulses exactly 1 cycle.
  - After the decoder finishes, data_out=39'h0, data_valid=1, and strand_count goes 0→1 on data_ready.
- Strand of 32 nucleotides cycling ACGT: dec_message=64'h1B1B_1B1B_1B1B_1B1B, and the MSB-first ordering is checked.
- nuc_last on the 10th nucleotide:
  - frame_err pulses 1 cycle and no dec_start occurs.
  - A following good strand decodes normally.
- 40 nucleotides with nuc_last on the 40th:
  - DROP is entered after the 32nd and frame_err pulses after the 40th.
  - No dec_start and strand_count unchanged.
- Back-to-back strands with data_ready held low for 20 cycles:
  - nuc_ready stays 0 until data_ready is asserted and the second strand waits.
  - The second launch ignores the stale high finish flag until it drops.
- resetN pulsed low while 15 nucleotides are buffered:
  - All outputs return to reset values.
  - The next full strand produces the correct dec_message.
